// File: rtl/leibniz_pkg.sv
// Shared types and defaults for the time-shared Leibniz pi series scheduler.
package leibniz_pkg;

    localparam int NBITS_DEF   = 64;
    localparam int DIV_LAT_DEF = 4;
    localparam int TBITS_DEF   = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef struct packed {
        logic valid;
        logic sign;
    } tag_t;

endpackage

// File: rtl/leibniz_tag_pipe.sv
// Shift register of {valid, sign} tags that travels in lockstep with the divider pipeline.
module leibniz_tag_pipe
    import leibniz_pkg::*;
#(
    parameter int DEPTH = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic in_valid,
    input  logic in_sign,
    output logic out_valid,
    output logic out_sign,
    output logic any_valid,
    output logic upstream_valid
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= '{valid: in_valid, sign: in_sign};
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign out_valid = stages[DEPTH-1].valid;
    assign out_sign  = stages[DEPTH-1].sign;

    // upstream_valid ignores the output stage: those tags still have cycles to travel.
    always_comb begin
        any_valid      = 1'b0;
        upstream_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i].valid;
        for (int i = 0; i < DEPTH - 1; i++) upstream_valid = upstream_valid | stages[i].valid;
    end

endmodule

// File: rtl/leibniz_term_scheduler.sv
// Feeds one shared pipelined divider with Leibniz terms NUMER/(2k+1) and
// accumulates the returning quotients with alternating sign.
module leibniz_term_scheduler
    import leibniz_pkg::*;
#(
    parameter int NBITS   = NBITS_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int TBITS   = TBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [TBITS-1:0] n_terms,
    input  logic [NBITS-1:0] numer,
    output logic [NBITS-1:0] div_number,
    output logic [NBITS-1:0] div_denom,
    output logic             div_en,
    input  logic [NBITS-1:0] div_quotient,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] pi_result,
    output logic [TBITS-1:0] terms_done
);

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [NBITS-1:0]        k;
    logic [NBITS-1:0]        numer_lat;
    logic [TBITS-1:0]        n_lat;
    logic signed [NBITS-1:0] pi_acc;
    logic                    issue;
    logic                    last_term;
    logic                    launch;
    logic                    tail_valid;
    logic                    tail_sign;
    logic                    any_valid;
    logic                    upstream_valid;

    function automatic logic signed [NBITS-1:0] acc_step(
        input logic signed [NBITS-1:0] acc,
        input logic [NBITS-1:0]        quot,
        input logic                    neg
    );
        acc_step = neg ? acc - $signed(quot) : acc + $signed(quot);
    endfunction

    assign issue     = (state == ISSUE);
    assign last_term = (k == NBITS'(n_lat) - NBITS'(1));
    // The pipe is always empty in IDLE/DONE; the guard keeps a restart from mixing runs.
    assign launch    = start && ((state == IDLE) || (state == DONE)) && !any_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (launch) state_next = (n_terms != '0) ? ISSUE : DONE;
            ISSUE:      if (last_term) state_next = DRAIN;
            // Only the output-stage tag may remain; it is accumulated on this same edge.
            DRAIN:      if (!upstream_valid) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            k          <= '0;
            n_lat      <= '0;
            numer_lat  <= '0;
            pi_acc     <= '0;
            terms_done <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE) && ((state != DONE) || launch);
            if (launch) begin
                numer_lat  <= numer;
                n_lat      <= n_terms;
                k          <= '0;
                pi_acc     <= '0;
                terms_done <= '0;
            end else begin
                if (issue) k <= k + 1'b1;
                if (tail_valid) begin
                    pi_acc     <= acc_step(pi_acc, div_quotient, tail_sign);
                    terms_done <= terms_done + 1'b1;
                end
            end
        end
    end

    leibniz_tag_pipe #(
        .DEPTH(DIV_LAT)
    ) u_tag_pipe (
        .clk           (clk),
        .clear         (reset),
        .in_valid      (issue),
        .in_sign       (k[0]),
        .out_valid     (tail_valid),
        .out_sign      (tail_sign),
        .any_valid     (any_valid),
        .upstream_valid(upstream_valid)
    );

    assign div_en     = issue;
    assign div_number = numer_lat;
    assign div_denom  = {k[NBITS-2:0], 1'b1};
    assign busy       = issue || (state == DRAIN);
    assign pi_result  = pi_acc;

endmodule

// File: tb/tb_leibniz_term_scheduler.sv
// Scoreboard bench: three scheduler builds (DIV_LAT 4, 1, 8), each driving a behavioural divider.
module tb_leibniz_term_scheduler;

    localparam int NI = 3;
    localparam int NB = 64;
    localparam int TB = 16;

    typedef struct {
        int          g;
        logic [63:0] pi;
        int          terms;
        longint      at;
    } res_t;

    typedef struct {
        int          g;
        logic [63:0] num;
        logic [63:0] den;
    } iss_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] div_en;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [TB-1:0] n_terms    [NI];
    logic [TB-1:0] terms_done [NI];
    logic [NB-1:0] numer        [NI];
    logic [NB-1:0] div_number   [NI];
    logic [NB-1:0] div_denom    [NI];
    logic [NB-1:0] div_quotient [NI];
    logic [NB-1:0] pi_result    [NI];

    longint cyc = 0;
    int     nchecks = 0;
    int     nerr = 0;
    res_t   res_q[$];
    iss_t   iss_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        logic [NB-1:0] qp [L];

        leibniz_term_scheduler #(
            .NBITS  (NB),
            .DIV_LAT(L),
            .TBITS  (TB)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .n_terms     (n_terms[g]),
            .numer       (numer[g]),
            .div_number  (div_number[g]),
            .div_denom   (div_denom[g]),
            .div_en      (div_en[g]),
            .div_quotient(div_quotient[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .pi_result   (pi_result[g]),
            .terms_done  (terms_done[g])
        );

        // Divider model keeps emitting junk when idle so untagged quotients must be ignored.
        always @(posedge clk) begin
            qp[0] <= div_en[g] ? div_number[g] / div_denom[g] : 64'h0BAD_0000_0000_0777;
            for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
        end
        assign div_quotient[g] = qp[L-1];
    end

    function automatic int lat_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] leib_ref(input logic [63:0] nm, input int n);
        logic [63:0] acc;
        logic [63:0] q;
        acc = '0;
        for (int k = 0; k < n; k++) begin
            q   = nm / 64'(2 * k + 1);
            acc = (k % 2 == 1) ? acc - q : acc + q;
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (res_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout_pending", 64'(res_q.size()), 64'd0);
        res_q.delete();
        repeat (4) @(negedge clk);
        check("issue_leftover", 64'(iss_q.size()), 64'd0);
        iss_q.delete();
    endtask

    // Queue expectations, pulse start, and optionally hammer start while the run is busy.
    task automatic run(input int g, input logic [63:0] nm, input int n,
                       input logic [63:0] exp_pi, input bit pester);
        longint s;
        for (int k = 0; k < n; k++) iss_q.push_back('{g, nm, 64'(2 * k + 1)});
        @(negedge clk);
        s = cyc + 1;
        // done is seen on the negedge after edge s+n+lat, i.e. in the cycle ending at s+n+lat+1.
        res_q.push_back('{g, exp_pi, n, (n == 0) ? s : s + longint'(n + lat_of(g))});
        start[g]   = 1'b1;
        numer[g]   = nm;
        n_terms[g] = TB'(n);
        @(negedge clk);
        start[g] = 1'b0;
        check("clear_pi", pi_result[g], 64'd0);
        check("clear_terms", 64'(terms_done[g]), 64'd0);
        check("busy_after_start", 64'(busy[g]), (n == 0) ? 64'd0 : 64'd1);
        if (pester) begin
            for (int i = 0; i < 3; i++) begin
                start[g]   = 1'b1;
                n_terms[g] = 16'd7;
                numer[g]   = 64'd999;
                @(negedge clk);
                start[g] = 1'b0;
                @(negedge clk);
            end
        end
        wait_done(n + lat_of(g) + 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", nerr);
        $fatal(1);
    end

    initial begin
        iss_t ie;
        res_t re;
        longint s;
        for (int g = 0; g < NI; g++) begin
            n_terms[g] = '0;
            numer[g]   = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_pi", pi_result[0], 64'd0);
        check("reset_terms", 64'(terms_done[0]), 64'd0);
        check("reset_busy", 64'(busy[0]), 64'd0);
        check("reset_done", 64'(done[0]), 64'd0);
        check("reset_div_en", 64'(div_en[0]), 64'd0);
        reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < NI; g++) begin
                    if (div_en[g]) begin
                        if (iss_q.size() == 0) begin
                            check("div_en_unexpected", 64'(div_en[g]), 64'd0);
                        end else begin
                            ie = iss_q.pop_front();
                            check("issue_inst", 64'(g), 64'(ie.g));
                            check("div_number", div_number[g], ie.num);
                            check("div_denom", div_denom[g], ie.den);
                        end
                    end
                    if (done[g]) begin
                        if (res_q.size() == 0) begin
                            check("done_unexpected", 64'(done[g]), 64'd0);
                        end else begin
                            re = res_q.pop_front();
                            check("done_inst", 64'(g), 64'(re.g));
                            check("pi_result", pi_result[g], re.pi);
                            check("terms_done", 64'(terms_done[g]), 64'(re.terms));
                            check("done_cycle", 64'(cyc), 64'(re.at));
                        end
                    end
                end
            end
        join_none

        // Single term, four terms, and the empty series.
        run(0, 64'd131072, 1, 64'd131072, 1'b0);
        run(0, 64'd131072, 4, 64'd94872, 1'b0);
        run(0, 64'd131072, 0, 64'd0, 1'b0);

        // Reset in the second DRAIN cycle of an 8-term run drops all in-flight results.
        for (int k = 0; k < 8; k++) iss_q.push_back('{0, 64'd131072, 64'(2 * k + 1)});
        @(negedge clk);
        start[0]   = 1'b1;
        numer[0]   = 64'd131072;
        n_terms[0] = 16'd8;
        @(negedge clk);
        start[0] = 1'b0;
        s = cyc;
        repeat (9) @(negedge clk);
        check("pre_reset_cycle", 64'(cyc), 64'(s + 9));
        check("pre_reset_busy", 64'(busy[0]), 64'd1);
        check("pre_reset_terms", 64'(terms_done[0]), 64'd5);
        check("pre_reset_pi", pi_result[0], 64'd109435);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_reset_pi", pi_result[0], 64'd0);
        check("post_reset_terms", 64'(terms_done[0]), 64'd0);
        check("post_reset_busy", 64'(busy[0]), 64'd0);
        check("post_reset_done", 64'(done[0]), 64'd0);
        repeat (12) @(negedge clk);
        check("stale_pi", pi_result[0], 64'd0);
        check("stale_terms", 64'(terms_done[0]), 64'd0);
        check("reset_issue_leftover", 64'(iss_q.size()), 64'd0);
        iss_q.delete();
        run(0, 64'd131072, 2, 64'd87382, 1'b0);

        // start while busy is ignored; start from DONE restarts cleanly.
        run(0, 64'd131072, 4, 64'd94872, 1'b1);
        run(0, 64'd131072, 2, 64'd87382, 1'b0);

        // Latency extremes against the reference sum of truncated terms.
        run(1, 64'd131072, 100, leib_ref(64'd131072, 100), 1'b0);
        run(2, 64'd131072, 100, leib_ref(64'd131072, 100), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/leibniz_term_scheduler.md
Name: leibniz_term_scheduler

Overview:
Sequences one shared pipelined divider to compute the Leibniz series for pi in fixed point: pi ≈ sum over k of (-1)^k · NUMER/(2k+1).
- Issues one term per cycle into the divider and tracks in-flight terms with a tag pipeline.
- Accumulates the returning quotients with alternating sign and reports the final sum.
- Sits between the top-level switch/LCD glue and the `divi` divider instance. It replaces the fixed bank of parallel dividers with one time-shared divider.

Parameters:
- NBITS, 64, width of numerator, denominator, quotient and accumulator.
- DIV_LAT, 4, divider pipeline latency in clocks (number/denom in, quotient valid DIV_LAT cycles later); must be ≥1.
- TBITS, 16, width of term counter.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, reset.
- start, input, 1, begin computation; sampled only in IDLE or DONE.
- n_terms, input, TBITS, number of series terms; sampled with start.
- numer, input, NBITS, scaled numerator (e.g. 4<<15); sampled with start.
- div_number, output, NBITS, numerator to divider.
- div_denom, output, NBITS, denominator to divider.
- div_en, output, 1, high when div_number/div_denom carry a valid term this cycle.
- div_quotient, input, NBITS, divider result (unsigned).
- busy, output, 1, high in ISSUE or DRAIN.
- done, output, 1, one-cycle pulse when the result becomes final.
- pi_result, output, NBITS, signed two's-complement accumulated sum; held until the next start.
- terms_done, output, TBITS, count of quotients accumulated so far.

Behaviour:
- Reset is synchronous, active-high. On reset:
  - state = IDLE;
  - pi_result, terms_done, k, latched numer/n_terms = 0;
  - tag pipeline fully cleared (all valid = 0);
  - div_en = 0, busy = 0, done = 0.
- States and transitions:
  - IDLE: on start, latch numer and n_terms. Go to ISSUE if n_terms > 0, else go to DONE with pi_result = 0.
  - ISSUE:
    - Each cycle: div_en = 1, div_number = latched numer, div_denom = 2·k+1 (NBITS, zero-extended), k increments.
    - A tag {valid = 1, sign = k[0]} enters stage 0 of a DIV_LAT-deep shift register.
    - When k == n_terms-1 is issued, go to DRAIN.
  - DRAIN: div_en = 0. Tags continue shifting. When the pipeline holds no valid tag and no accumulation is pending, go to DONE.
  - DONE: done = 1 for exactly the entry cycle. Stay in DONE while pi_result holds. A start here restarts exactly as from IDLE: pi_result, terms_done and k clear at the start edge.
- Accumulation:
  - When the tag at stage DIV_LAT-1 is valid, div_quotient is consumed in that cycle.
  - pi_result += quotient if sign = 0, else pi_result -= quotient. The result is registered at the next edge.
  - terms_done increments by 1 on each accumulation.
  - Arithmetic wraps modulo 2^NBITS; no saturation.
- Latency: if start is sampled at edge 0, the last accumulate lands at edge n_terms+DIV_LAT and done is high during the following cycle. start-to-done = n_terms + DIV_LAT + 1 cycles.
- Quotients arriving without a valid tag are ignored. This covers stale divider output after reset or restart.
- start while busy is ignored. n_terms and numer are not re-sampled mid-run.
- Reset mid-run clears all tags, so in-flight divider results are never accumulated.
- n_terms = 2^TBITS-1 must run to completion. k must not overflow the 2k+1 computation; k is NBITS wide internally.

Decomposition:
- Package leibniz_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the tag struct {valid, sign};
  - default NBITS/DIV_LAT/TBITS constants.
- One sub-module, leibniz_tag_pipe: a parameterized DIV_LAT-deep shift register of tags with synchronous clear and an any_valid output. The scheduler instantiates it.
- The divider itself stays outside; a behavioural DIV_LAT-stage divider model is used in the bench.

Test Plan:
1. numer=131072, n_terms=1 → div_denom=1 once; pi_result=131072, terms_done=1, done pulses at start+DIV_LAT+2 cycles.
2. numer=131072, n_terms=4 → denoms 1,3,5,7 on consecutive cycles; pi_result=131072-43690+26214-18724=94872, done pulses exactly once.
3. n_terms=0 → no div_en, done pulses the cycle after start, pi_result=0, busy never asserted.
4. Start n_terms=8; assert reset for 1 cycle at the 2nd DRAIN cycle; model keeps emitting quotients → pi_result stays 0, terms_done=0, no done. A following run with n_terms=2 returns 87382.
5. Start pulsed repeatedly during ISSUE/DRAIN of an n_terms=4 run → ignored, result 94872. Start again in DONE with n_terms=2 → result clears, then 87382.
6. DIV_LAT=1 and DIV_LAT=8 builds, n_terms=100, numer=4<<15 → pi_result matches the bench reference sum of integer-truncated terms; done at n_terms+DIV_LAT+1 cycles after start.
